// File: rtl/acc_cpu_core.sv
// Accumulator CPU stepping fetch/wait/exec over a synchronous ROM; step-to-retire = 2+IMEM_LAT clk.
// run_en=0 freezes the step prescaler only; an instruction already in flight still completes.
module acc_cpu_core #(
    parameter int DATA_W    = 4,
    parameter int ADDR_W    = 5,
    parameter int INSTR_W   = 8,
    parameter int LAST_ADDR = 14,
    parameter int IMEM_LAT  = 1,
    parameter int STEP_DIV  = 10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  acc,
    output logic [ADDR_W-1:0]  pc,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_c,
    output logic               halted,
    output logic               retire,
    output logic [6:0]         seg
);
    localparam int IMM_W  = INSTR_W - 3;
    localparam int DIV_W  = $clog2(STEP_DIV);
    localparam int WAIT_W = (IMEM_LAT > 2) ? $clog2(IMEM_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(LAST_ADDR);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(IMEM_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

    state_t              r_state, w_state_nxt;
    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [DIV_W-1:0]    r_div;
    logic                w_div_last, w_step;
    logic [WAIT_W-1:0]   r_wait;
    logic [ADDR_W-1:0]   r_imem_addr, r_pc;
    logic [DATA_W-1:0]   r_acc;
    logic                r_z, r_n, r_c, r_halted, r_retire;

    logic [2:0]          w_op;
    logic [IMM_W-1:0]    w_imm;
    logic [DATA_W-1:0]   w_imm_d, w_diff, w_acc_nxt;
    logic [DATA_W:0]     w_sum;
    logic [ADDR_W-1:0]   w_tgt_raw, w_tgt, w_pc_inc, w_pc_nxt;
    logic                w_z_nxt, w_n_nxt, w_c_nxt, w_halt_nxt;
    logic [6:0]          w_seg;

    // Reset asserts immediately but releases two clocks later, aligned to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_div_last = (r_div == DIV_LAST);
    assign w_step     = run_en & w_div_last;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)    r_div <= '0;
        else if (run_en) r_div <= w_div_last ? '0 : r_div + 1'b1;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_step && !r_halted) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  if (r_wait == '0) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = w_halt_nxt ? S_HALT : S_IDLE;
            default: w_state_nxt = S_HALT;
        endcase
    end

    assign w_op      = imem_data[INSTR_W-1:INSTR_W-3];
    assign w_imm     = imem_data[IMM_W-1:0];
    assign w_imm_d   = DATA_W'(w_imm);
    assign w_tgt_raw = ADDR_W'(w_imm);
    assign w_tgt     = (w_tgt_raw > LAST_PC) ? '0 : w_tgt_raw;
    assign w_pc_inc  = (r_pc == LAST_PC) ? '0 : r_pc + 1'b1;
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_imm_d};
    assign w_diff    = r_acc - w_imm_d;

    always_comb begin
        w_acc_nxt  = r_acc;
        w_pc_nxt   = w_pc_inc;
        w_z_nxt    = r_z;
        w_n_nxt    = r_n;
        w_c_nxt    = r_c;
        w_halt_nxt = 1'b0;
        case (w_op)
            3'd0: ;
            3'd1: begin
                w_acc_nxt = w_imm_d;
                w_z_nxt   = (w_imm_d == '0);
                w_n_nxt   = 1'b0;
                w_c_nxt   = 1'b0;
            end
            3'd2: begin
                {w_c_nxt, w_acc_nxt} = w_sum;
                w_z_nxt = (w_sum[DATA_W-1:0] == '0);
                w_n_nxt = 1'b0;
            end
            3'd3: begin
                w_acc_nxt = w_diff;
                w_n_nxt   = (r_acc < w_imm_d);
                w_z_nxt   = (w_diff == '0);
                w_c_nxt   = 1'b0;
            end
            3'd4: w_pc_nxt = w_tgt;
            3'd5: w_pc_nxt = r_n ? w_tgt : w_pc_inc;
            3'd6: w_pc_nxt = r_z ? w_tgt : w_pc_inc;
            default: begin
                w_pc_nxt   = r_pc;
                w_halt_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_imem_addr <= '0;
            r_wait      <= '0;
            r_pc        <= '0;
            r_acc       <= '0;
            r_z         <= 1'b0;
            r_n         <= 1'b0;
            r_c         <= 1'b0;
            r_halted    <= 1'b0;
            r_retire    <= 1'b0;
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_imem_addr <= r_pc;
                    r_wait      <= WAIT_INIT;
                end
                S_WAIT: if (r_wait != '0) r_wait <= r_wait - 1'b1;
                S_EXEC: begin
                    r_retire <= 1'b1;
                    r_acc    <= w_acc_nxt;
                    r_pc     <= w_pc_nxt;
                    r_z      <= w_z_nxt;
                    r_n      <= w_n_nxt;
                    r_c      <= w_c_nxt;
                    if (w_halt_nxt) r_halted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Active-low segments, bit 6 = a ... bit 0 = g.
    always_comb begin
        w_seg = 7'b1111111;
        case (r_acc[3:0])
            4'h0: w_seg = 7'b0000001;
            4'h1: w_seg = 7'b1001111;
            4'h2: w_seg = 7'b0010010;
            4'h3: w_seg = 7'b0000110;
            4'h4: w_seg = 7'b1001100;
            4'h5: w_seg = 7'b0100100;
            4'h6: w_seg = 7'b0100000;
            4'h7: w_seg = 7'b0001111;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0000100;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b1100000;
            4'hC: w_seg = 7'b0110001;
            4'hD: w_seg = 7'b1000010;
            4'hE: w_seg = 7'b0110000;
            default: w_seg = 7'b0111000;
        endcase
    end

    assign imem_addr = r_imem_addr;
    assign acc       = r_acc;
    assign pc        = r_pc;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign flag_c    = r_c;
    assign halted    = r_halted;
    assign retire    = r_retire;
    assign seg       = w_seg;
endmodule
